// File: rtl/blink_sched.sv
// LED pattern step scheduler: a prescaled base tick drives a speed-selectable step
// counter through three fixed-length patterns, with run/pause/demo control.
module blink_sched #(
    parameter int TICK_DIV   = 8388608,
    parameter int DEMO_STEPS = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_p,
    input  logic       run_p,
    input  logic       demo,
    input  logic [1:0] speed,
    output logic [1:0] pat,
    output logic [2:0] step,
    output logic       step_en,
    output logic       running,
    output logic [1:0] state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DEMO  = 2'd3;

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEMO_STEPS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEMO_LAST  = DW'(DEMO_STEPS - 1);

    logic [PW-1:0] presc;
    logic [2:0]    sub;
    logic [DW-1:0] demo_cnt;

    logic       active;
    logic       base_tick;
    logic       step_evt;
    logic       demo_adv;
    logic       pat_adv;
    logic [2:0] sub_lim;
    logic [2:0] step_last;
    logic [1:0] next_state;

    always_comb begin
        active    = (state == S_RUN) || (state == S_DEMO);
        base_tick = active && (presc == PRESC_LAST);
        case (speed)
            2'd0:    sub_lim = 3'd0;
            2'd1:    sub_lim = 3'd1;
            2'd2:    sub_lim = 3'd3;
            default: sub_lim = 3'd7;
        endcase
        // Greater-or-equal lets a lowered speed setting step on the very next base tick.
        step_evt  = base_tick && (sub >= sub_lim);
        demo_adv  = step_evt && (state == S_DEMO) && (demo_cnt == DEMO_LAST);
        pat_adv   = mode_p || demo_adv;
        step_last = (pat == 2'd0) ? 3'd5 : 3'd3;

        next_state = state;
        case (state)
            S_IDLE, S_PAUSE: if (run_p) next_state = demo ? S_DEMO : S_RUN;
            S_RUN: begin
                if (run_p)     next_state = S_PAUSE;
                else if (demo) next_state = S_DEMO;
            end
            default: begin
                if (run_p)      next_state = S_PAUSE;
                else if (!demo) next_state = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            running  <= 1'b0;
            pat      <= 2'd0;
            step     <= 3'd0;
            step_en  <= 1'b0;
            presc    <= '0;
            sub      <= 3'd0;
            demo_cnt <= '0;
        end else begin
            state   <= next_state;
            running <= (next_state == S_RUN) || (next_state == S_DEMO);
            step_en <= 1'b0;
            // A pattern advance overrides any step event landing in the same cycle.
            if (pat_adv) begin
                pat      <= (pat == 2'd2) ? 2'd0 : pat + 2'd1;
                step     <= 3'd0;
                presc    <= '0;
                sub      <= 3'd0;
                demo_cnt <= '0;
            end else if (active) begin
                presc <= base_tick ? '0 : presc + 1'b1;
                if (step_evt) begin
                    sub     <= 3'd0;
                    step    <= (step == step_last) ? 3'd0 : step + 3'd1;
                    step_en <= 1'b1;
                    if (state == S_DEMO) demo_cnt <= demo_cnt + 1'b1;
                end else if (base_tick) begin
                    sub <= sub + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_blink_sched.sv
// Self-checking bench for blink_sched with TICK_DIV=4, DEMO_STEPS=3; expected step
// events are queued as stimulus is driven and compared as STEP_EN pulses arrive.
module tb_blink_sched;

    logic       clk;
    logic       rst;
    logic       mode_p;
    logic       run_p;
    logic       demo;
    logic [1:0] speed;
    logic [1:0] pat;
    logic [2:0] step;
    logic       step_en;
    logic       running;
    logic [1:0] state;

    typedef struct {
        logic [1:0] pat;
        logic [2:0] step;
        int         gap;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    blink_sched #(.TICK_DIV(4), .DEMO_STEPS(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .mode_p  (mode_p),
        .run_p   (run_p),
        .demo    (demo),
        .speed   (speed),
        .pat     (pat),
        .step    (step),
        .step_en (step_en),
        .running (running),
        .state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits for the next STEP_EN pulse; gap is cycles waited, -1 if none arrived.
    task automatic wait_step(output int gap);
        gap = 0;
        do begin
            @(posedge clk);
            #1;
            gap++;
        end while (step_en !== 1'b1 && gap < 200);
        if (step_en !== 1'b1) gap = -1;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1; run_p = 1'b1; mode_p = 1'b1;
        cycle(1);
        rst = 1'b0; run_p = 1'b0; mode_p = 1'b0;
        checks++;
        if (state !== 2'd0 || pat !== 2'd0 || step !== 3'd0 || step_en !== 1'b0 || running !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_state: got state=%0d pat=%0d step=%0d en=%0b run=%0b, want all 0",
                     state, pat, step, step_en, running);
        end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1);
            if (state !== 2'd0 || pat !== 2'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            fails++;
            $display("[TB] FAIL reset_ignores_pulses: got %0d bad cycles, want 0", bad);
        end
    endtask

    task automatic test_run();
        int g;
        speed = 2'd0; demo = 1'b0;
        run_p = 1'b1;
        cycle(1);
        run_p = 1'b0;
        checks++;
        if (state !== 2'd1 || running !== 1'b1) begin
            fails++;
            $display("[TB] FAIL run_start: got state=%0d run=%0b, want state=1 run=1", state, running);
        end
        sb.push_back('{2'd0, 3'd1, 4});
        sb.push_back('{2'd0, 3'd2, 4});
        sb.push_back('{2'd0, 3'd3, 4});
        sb.push_back('{2'd0, 3'd4, 4});
        sb.push_back('{2'd0, 3'd5, 4});
        sb.push_back('{2'd0, 3'd0, 4});
        sb.push_back('{2'd0, 3'd1, 4});
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            wait_step(g);
            checks++;
            if (g !== e.gap || step !== e.step || pat !== e.pat) begin
                fails++;
                $display("[TB] FAIL run_step: got pat=%0d step=%0d gap=%0d, want pat=%0d step=%0d gap=%0d",
                         pat, step, g, e.pat, e.step, e.gap);
            end
        end
    endtask

    task automatic test_speed();
        int g;
        int seen;
        speed = 2'd2;
        sb.push_back('{2'd0, 3'd2, 16});
        sb.push_back('{2'd0, 3'd3, 16});
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            wait_step(g);
            checks++;
            if (g !== e.gap || step !== e.step || pat !== e.pat) begin
                fails++;
                $display("[TB] FAIL speed2_step: got pat=%0d step=%0d gap=%0d, want pat=%0d step=%0d gap=%0d",
                         pat, step, g, e.pat, e.step, e.gap);
            end
        end
        // Five base ticks at speed 3 leave the sub-counter at 5 with no step.
        speed = 2'd3;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1);
            if (step_en === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            fails++;
            $display("[TB] FAIL speed3_partial: got %0d step pulses, want 0", seen);
        end
        speed = 2'd0;
        sb.push_back('{2'd0, 3'd4, 4});
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            wait_step(g);
            checks++;
            if (g !== e.gap || step !== e.step || pat !== e.pat) begin
                fails++;
                $display("[TB] FAIL speed_lowered: got pat=%0d step=%0d gap=%0d, want pat=%0d step=%0d gap=%0d",
                         pat, step, g, e.pat, e.step, e.gap);
            end
        end
    endtask

    task automatic test_pause();
        int g;
        int bad;
        run_p = 1'b1;
        cycle(1);
        run_p = 1'b0;
        checks++;
        if (state !== 2'd2 || running !== 1'b0 || step !== 3'd4) begin
            fails++;
            $display("[TB] FAIL pause_enter: got state=%0d run=%0b step=%0d, want state=2 run=0 step=4",
                     state, running, step);
        end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            cycle(1);
            if (state !== 2'd2 || step !== 3'd4 || pat !== 2'd0 || step_en !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            fails++;
            $display("[TB] FAIL pause_hold: got %0d bad cycles, want 0", bad);
        end
        run_p = 1'b1;
        cycle(1);
        run_p = 1'b0;
        checks++;
        if (state !== 2'd1) begin
            fails++;
            $display("[TB] FAIL pause_resume: got state=%0d, want 1", state);
        end
        sb.push_back('{2'd0, 3'd5, 3});
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            wait_step(g);
            checks++;
            if (g !== e.gap || step !== e.step || pat !== e.pat) begin
                fails++;
                $display("[TB] FAIL resume_partial: got pat=%0d step=%0d gap=%0d, want pat=%0d step=%0d gap=%0d",
                         pat, step, g, e.pat, e.step, e.gap);
            end
        end
    endtask

    task automatic test_mode_collision();
        int g;
        sb.push_back('{2'd0, 3'd0, 4});
        sb.push_back('{2'd0, 3'd1, 4});
        sb.push_back('{2'd0, 3'd2, 4});
        sb.push_back('{2'd0, 3'd3, 4});
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            wait_step(g);
            checks++;
            if (g !== e.gap || step !== e.step || pat !== e.pat) begin
                fails++;
                $display("[TB] FAIL approach_step: got pat=%0d step=%0d gap=%0d, want pat=%0d step=%0d gap=%0d",
                         pat, step, g, e.pat, e.step, e.gap);
            end
        end
        cycle(3);
        mode_p = 1'b1;
        cycle(1);
        mode_p = 1'b0;
        checks++;
        if (pat !== 2'd1 || step !== 3'd0 || step_en !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mode_on_step: got pat=%0d step=%0d en=%0b, want pat=1 step=0 en=0",
                     pat, step, step_en);
        end
        sb.push_back('{2'd1, 3'd1, 4});
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            wait_step(g);
            checks++;
            if (g !== e.gap || step !== e.step || pat !== e.pat) begin
                fails++;
                $display("[TB] FAIL after_mode: got pat=%0d step=%0d gap=%0d, want pat=%0d step=%0d gap=%0d",
                         pat, step, g, e.pat, e.step, e.gap);
            end
        end
    endtask

    task automatic test_demo();
        int g;
        rst = 1'b1;
        cycle(1);
        rst = 1'b0;
        demo = 1'b1;
        cycle(1);
        run_p = 1'b1;
        cycle(1);
        run_p = 1'b0;
        checks++;
        if (state !== 2'd3 || running !== 1'b1) begin
            fails++;
            $display("[TB] FAIL demo_enter: got state=%0d run=%0b, want state=3 run=1", state, running);
        end
        // Every third step event becomes a silent pattern advance.
        sb.push_back('{2'd0, 3'd1, 4});
        sb.push_back('{2'd0, 3'd2, 4});
        sb.push_back('{2'd1, 3'd1, 8});
        sb.push_back('{2'd1, 3'd2, 4});
        sb.push_back('{2'd2, 3'd1, 8});
        sb.push_back('{2'd2, 3'd2, 4});
        sb.push_back('{2'd0, 3'd1, 8});
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            wait_step(g);
            checks++;
            if (g !== e.gap || step !== e.step || pat !== e.pat) begin
                fails++;
                $display("[TB] FAIL demo_step: got pat=%0d step=%0d gap=%0d, want pat=%0d step=%0d gap=%0d",
                         pat, step, g, e.pat, e.step, e.gap);
            end
        end
        demo = 1'b0;
        cycle(1);
        checks++;
        if (state !== 2'd1 || pat !== 2'd0 || running !== 1'b1) begin
            fails++;
            $display("[TB] FAIL demo_exit: got state=%0d pat=%0d run=%0b, want state=1 pat=0 run=1",
                     state, pat, running);
        end
        sb.push_back('{2'd0, 3'd2, 3});
        sb.push_back('{2'd0, 3'd3, 4});
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            wait_step(g);
            checks++;
            if (g !== e.gap || step !== e.step || pat !== e.pat) begin
                fails++;
                $display("[TB] FAIL post_demo_step: got pat=%0d step=%0d gap=%0d, want pat=%0d step=%0d gap=%0d",
                         pat, step, g, e.pat, e.step, e.gap);
            end
        end
    endtask

    task automatic test_reset_mid_demo();
        int g;
        int seen;
        rst = 1'b1;
        cycle(1);
        rst = 1'b0;
        demo = 1'b1;
        run_p = 1'b1;
        cycle(1);
        run_p = 1'b0;
        sb.push_back('{2'd0, 3'd1, 4});
        sb.push_back('{2'd0, 3'd2, 4});
        sb.push_back('{2'd1, 3'd1, 8});
        sb.push_back('{2'd1, 3'd2, 4});
        sb.push_back('{2'd2, 3'd1, 8});
        sb.push_back('{2'd2, 3'd2, 4});
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            wait_step(g);
            checks++;
            if (g !== e.gap || step !== e.step || pat !== e.pat) begin
                fails++;
                $display("[TB] FAIL reach_pat2: got pat=%0d step=%0d gap=%0d, want pat=%0d step=%0d gap=%0d",
                         pat, step, g, e.pat, e.step, e.gap);
            end
        end
        rst = 1'b1; run_p = 1'b1; mode_p = 1'b1;
        cycle(1);
        rst = 1'b0; run_p = 1'b0; mode_p = 1'b0;
        checks++;
        if (state !== 2'd0 || pat !== 2'd0 || step !== 3'd0 || running !== 1'b0 || step_en !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mid_demo_reset: got state=%0d pat=%0d step=%0d run=%0b en=%0b, want all 0",
                     state, pat, step, running, step_en);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1);
            if (step_en === 1'b1 || state !== 2'd0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            fails++;
            $display("[TB] FAIL post_reset_quiet: got %0d active cycles, want 0", seen);
        end
        demo = 1'b0;
    endtask

    task automatic test_back_to_back();
        int g;
        run_p = 1'b1; mode_p = 1'b1;
        cycle(1);
        run_p = 1'b0; mode_p = 1'b0;
        checks++;
        if (state !== 2'd1 || pat !== 2'd1 || step !== 3'd0) begin
            fails++;
            $display("[TB] FAIL run_and_mode: got state=%0d pat=%0d step=%0d, want state=1 pat=1 step=0",
                     state, pat, step);
        end
        cycle(3);
        run_p = 1'b1;
        cycle(1);
        run_p = 1'b0;
        checks++;
        if (step_en !== 1'b1 || step !== 3'd1 || state !== 2'd2 || running !== 1'b0) begin
            fails++;
            $display("[TB] FAIL run_on_step: got en=%0b step=%0d state=%0d run=%0b, want en=1 step=1 state=2 run=0",
                     step_en, step, state, running);
        end
        demo = 1'b1;
        run_p = 1'b1;
        cycle(1);
        run_p = 1'b0;
        sb.push_back('{2'd1, 3'd2, 4});
        sb.push_back('{2'd1, 3'd3, 4});
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            wait_step(g);
            checks++;
            if (g !== e.gap || step !== e.step || pat !== e.pat) begin
                fails++;
                $display("[TB] FAIL demo_resume_step: got pat=%0d step=%0d gap=%0d, want pat=%0d step=%0d gap=%0d",
                         pat, step, g, e.pat, e.step, e.gap);
            end
        end
        cycle(3);
        mode_p = 1'b1;
        cycle(1);
        mode_p = 1'b0;
        checks++;
        if (pat !== 2'd2 || step !== 3'd0 || step_en !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mode_on_auto_adv: got pat=%0d step=%0d en=%0b, want pat=2 step=0 en=0",
                     pat, step, step_en);
        end
        sb.push_back('{2'd2, 3'd1, 4});
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            wait_step(g);
            checks++;
            if (g !== e.gap || step !== e.step || pat !== e.pat) begin
                fails++;
                $display("[TB] FAIL after_auto_adv: got pat=%0d step=%0d gap=%0d, want pat=%0d step=%0d gap=%0d",
                         pat, step, g, e.pat, e.step, e.gap);
            end
        end
        demo = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mode_p = 1'b0; run_p = 1'b0; demo = 1'b0; speed = 2'd0;
        cycle(2);
        test_reset();
        test_run();
        test_speed();
        test_pause();
        test_mode_collision();
        test_demo();
        test_reset_mid_demo();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/blink_sched.md
BLINK_SCHED -- requirements
Module: blink_sched

Interface
REQ-001 Parameter TICK_DIV, 8388608, system-clock cycles per base tick (≥2; benches use 4).
REQ-002 Parameter DEMO_STEPS, 12, step events per pattern in demo mode (≥1).
REQ-003 CLK  input  1  single clock; all logic on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 MODE_P  input  1  debounced one-cycle pulse; advance pattern.
REQ-006 RUN_P  input  1  debounced one-cycle pulse; start/pause toggle.
REQ-007 DEMO  input  1  level; 1 = auto-advance pattern.
REQ-008 SPEED  input  2  step period select.
REQ-009 PAT  output  2  current pattern index (0..2; 3 never driven).
REQ-010 STEP  output  3  current step index within pattern.
REQ-011 STEP_EN  output  1  one-cycle pulse, high in the first cycle STEP holds a newly advanced value.
REQ-012 RUNNING  output  1  high in states RUN and DEMO.
REQ-013 STATE  output  2  IDLE=0, RUN=1, PAUSE=2, DEMO=3.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 and wrap only while RUNNING=1; base tick = prescaler at TICK_DIV-1.
REQ-016 Sub-counter SHALL count base ticks; step event = base tick with sub-counter ≥ (2^SPEED)-1; sub-counter then clears (SPEED 0/1/2/3 → 1/2/4/8 base ticks per step).
REQ-017 SPEED change mid-count: ≥ compare applies, so a lowered limit steps on the next base tick.
REQ-018 Pattern lengths: PAT0 = 6 steps, PAT1 = 4, PAT2 = 4; STEP SHALL wrap from length-1 to 0 on a step event.
REQ-019 Pattern advance: PAT 0→1→2→0, STEP←0, prescaler, sub-counter and demo counter ←0, no STEP_EN.
REQ-020 IDLE: RUN_P → RUN if DEMO=0, else DEMO; MODE_P → pattern advance.
REQ-021 RUN: RUN_P → PAUSE; DEMO=1 (no RUN_P) → DEMO; MODE_P → pattern advance.
REQ-022 PAUSE: prescaler, sub-counter, demo counter, PAT, STEP hold; RUN_P → RUN if DEMO=0, else DEMO; MODE_P → pattern advance.
REQ-023 DEMO: as RUN; demo counter increments per step event; step event reaching DEMO_STEPS → pattern advance instead of step; DEMO=0 → RUN; RUN_P → PAUSE.
REQ-024 RUN_P and MODE_P in same cycle: both applied (state change and pattern advance).
REQ-025 MODE_P coincident with step event: MODE_P wins; PAT advances, STEP=0, STEP_EN=0.
REQ-026 MODE_P coincident with demo auto-advance: exactly one pattern advance.
REQ-027 RUN_P coincident with step event in RUN/DEMO: step event completes (STEP_EN pulses), then state = PAUSE.
REQ-028 RUN_P in PAUSE SHALL resume with retained prescaler/sub-counter values (no restart of partial period).

Reset
REQ-029 RST=1 at a clock edge: STATE=IDLE, PAT=0, STEP=0, STEP_EN=0, RUNNING=0, all internal counters 0, in the next cycle, regardless of state or concurrent inputs.
REQ-030 Inputs pulsed during a reset cycle SHALL be ignored.

Verification (TICK_DIV=4, DEMO_STEPS=3)
REQ-031 Reset, SPEED=0, RUN_P → STATE=1, STEP_EN every 4 cycles, STEP 1,2,3,4,5,0,1.
REQ-032 SPEED=2 in RUN → STEP_EN every 16 cycles; switch SPEED 3→0 with sub-counter=5 → step at next base tick.
REQ-033 RUN_P in RUN → STATE=2, STEP/PAT constant and STEP_EN=0 for 50 cycles; RUN_P → STATE=1, first STEP_EN at remaining partial period.
REQ-034 MODE_P on step-event cycle with PAT=0, STEP=3 → PAT=1, STEP=0, STEP_EN=0; next STEP_EN after 4 cycles with STEP=1.
REQ-035 DEMO=1 then RUN_P from IDLE → STATE=3; PAT 0→1→2→0 after every 3 step events; DEMO=0 → STATE=1, PAT held.
REQ-036 RST for 1 cycle mid-DEMO with PAT=2, STEP=2 → next cycle STATE=0, PAT=0, STEP=0, RUNNING=0, no STEP_EN for 20 cycles.
